// File: rtl/v_pipe_update.sv
// Four-stage read-modify-write pipeline applying ADD/DELETE/REPLACE commands to a per-product state RAM.
// Optional feature: define V_PIPE_UPDATE_ERRCNT_EN to add the saturating error counter output o_upd_err_cnt_r.
package v_pkg;
  localparam int unsigned ENTRIES_N = 4;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned LEVEL_W   = $clog2(ENTRIES_N);
  localparam int unsigned KEY_W     = 16;
  localparam int unsigned VOL_W     = 16;
  localparam int unsigned LS_W      = $clog2(ENTRIES_N + 1);

  typedef logic [ID_W-1:0]    id_t;
  typedef logic [ID_W-1:0]    addr_t;
  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [KEY_W-1:0]   key_t;
  typedef logic [VOL_W-1:0]   volume_t;
  typedef logic [LS_W-1:0]    listsize_t;

  typedef struct packed {
    logic [ENTRIES_N-1:0]    vld;
    key_t    [ENTRIES_N-1:0] key;
    volume_t [ENTRIES_N-1:0] volume;
    listsize_t               listsize;
  } state_t;

  localparam logic [1:0] CMD_ADD = 2'd0;
  localparam logic [1:0] CMD_DEL = 2'd1;
  localparam logic [1:0] CMD_REP = 2'd2;
endpackage

module v_pipe_update
  import v_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic       i_upd_vld,
  input  id_t        i_upd_prod_id,
  input  level_t     i_upd_level,
  input  logic [1:0] i_upd_cmd,
  input  key_t       i_upd_key,
  input  volume_t    i_upd_size,
  output logic       o_upd_rdy,
  output logic       o_state_ren,
  output addr_t      o_state_raddr,
  input  state_t     i_state_rdata,
  output logic       o_state_wen,
  output addr_t      o_state_waddr,
  output state_t     o_state_wdata,
  output logic       o_s1_upd_vld_r,
  output id_t        o_s1_upd_prod_id_r,
  output logic       o_s2_upd_vld_r,
  output id_t        o_s2_upd_prod_id_r,
  output logic       o_s3_upd_vld_r,
  output id_t        o_s3_upd_prod_id_r,
  output logic       o_s4_upd_vld_r,
  output id_t        o_s4_upd_prod_id_r,
  output logic       o_upd_resp_vld_r,
`ifdef V_PIPE_UPDATE_ERRCNT_EN
  output logic [15:0] o_upd_err_cnt_r,
`endif
  output logic       o_upd_resp_error_r
);

  logic       s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic       s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d;
  logic       state_wen_q, state_wen_d;
  logic       resp_err_q, resp_err_d;

  id_t        s1_id_q, s1_id_d, s2_id_q, s2_id_d, s3_id_q, s3_id_d, s4_id_q, s4_id_d;
  level_t     s1_level_q, s1_level_d;
  logic [1:0] s1_cmd_q, s1_cmd_d;
  key_t       s1_key_q, s1_key_d;
  volume_t    s1_size_q, s1_size_d;
  logic       s2_err_q, s2_err_d, s3_err_q, s3_err_d;
  state_t     s2_state_q, s2_state_d, s3_state_q, s3_state_d;

  logic                 accept_c;
  logic [ENTRIES_N-1:0] s1_onehot_c;
  logic                 s1_hit_c;
  logic                 s1_err_c;
  state_t               s1_new_c;

  // Same-id hazard: the RAM copy is stale until the older command has written in S3.
  assign o_upd_rdy = ~((s1_vld_q && (s1_id_q == i_upd_prod_id)) ||
                       (s2_vld_q && (s2_id_q == i_upd_prod_id)) ||
                       (s3_vld_q && (s3_id_q == i_upd_prod_id)));
  assign accept_c      = i_upd_vld & o_upd_rdy;
  assign o_state_ren   = accept_c;
  assign o_state_raddr = addr_t'(i_upd_prod_id);

  // S1: error check and new-state computation against the freshly read entry.
  always_comb begin
    s1_onehot_c              = '0;
    s1_onehot_c[s1_level_q]  = 1'b1;
    s1_hit_c                 = |(i_state_rdata.vld & s1_onehot_c);
    s1_new_c                 = i_state_rdata;
    s1_err_c                 = 1'b0;
    case (s1_cmd_q)
      CMD_ADD: begin
        s1_err_c                    = s1_hit_c;
        s1_new_c.vld                = i_state_rdata.vld | s1_onehot_c;
        s1_new_c.key[s1_level_q]    = s1_key_q;
        s1_new_c.volume[s1_level_q] = s1_size_q;
        s1_new_c.listsize           = i_state_rdata.listsize + listsize_t'(1);
      end
      CMD_DEL: begin
        s1_err_c          = ~s1_hit_c;
        s1_new_c.vld      = i_state_rdata.vld & ~s1_onehot_c;
        s1_new_c.listsize = i_state_rdata.listsize - listsize_t'(1);
      end
      CMD_REP: begin
        s1_err_c                    = ~s1_hit_c;
        s1_new_c.key[s1_level_q]    = s1_key_q;
        s1_new_c.volume[s1_level_q] = s1_size_q;
      end
      default: s1_err_c = 1'b1;
    endcase
  end

  // Stage advance; datapath registers only load when their source stage is valid.
  always_comb begin
    s1_vld_d    = accept_c;
    s2_vld_d    = s1_vld_q;
    s3_vld_d    = s2_vld_q;
    s4_vld_d    = s3_vld_q;
    state_wen_d = s2_vld_q & ~s2_err_q;
    resp_err_d  = s3_vld_q & s3_err_q;
    s1_id_d     = s1_id_q;
    s1_level_d  = s1_level_q;
    s1_cmd_d    = s1_cmd_q;
    s1_key_d    = s1_key_q;
    s1_size_d   = s1_size_q;
    s2_id_d     = s2_id_q;
    s2_err_d    = s2_err_q;
    s2_state_d  = s2_state_q;
    s3_id_d     = s3_id_q;
    s3_err_d    = s3_err_q;
    s3_state_d  = s3_state_q;
    s4_id_d     = s4_id_q;
    if (accept_c) begin
      s1_id_d    = i_upd_prod_id;
      s1_level_d = i_upd_level;
      s1_cmd_d   = i_upd_cmd;
      s1_key_d   = i_upd_key;
      s1_size_d  = i_upd_size;
    end
    if (s1_vld_q) begin
      s2_id_d    = s1_id_q;
      s2_err_d   = s1_err_c;
      s2_state_d = s1_new_c;
    end
    if (s2_vld_q) begin
      s3_id_d    = s2_id_q;
      s3_err_d   = s2_err_q;
      s3_state_d = s2_state_q;
    end
    if (s3_vld_q) begin
      s4_id_d = s3_id_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      s4_vld_q    <= 1'b0;
      state_wen_q <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      s3_vld_q    <= s3_vld_d;
      s4_vld_q    <= s4_vld_d;
      state_wen_q <= state_wen_d;
      resp_err_q  <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_id_q    <= s1_id_d;
    s1_level_q <= s1_level_d;
    s1_cmd_q   <= s1_cmd_d;
    s1_key_q   <= s1_key_d;
    s1_size_q  <= s1_size_d;
    s2_id_q    <= s2_id_d;
    s2_err_q   <= s2_err_d;
    s2_state_q <= s2_state_d;
    s3_id_q    <= s3_id_d;
    s3_err_q   <= s3_err_d;
    s3_state_q <= s3_state_d;
    s4_id_q    <= s4_id_d;
  end

`ifdef V_PIPE_UPDATE_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s4_vld_q && resp_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_upd_err_cnt_r = err_cnt_q;
`endif

  assign o_state_wen        = state_wen_q;
  assign o_state_waddr      = addr_t'(s3_id_q);
  assign o_state_wdata      = s3_state_q;
  assign o_s1_upd_vld_r     = s1_vld_q;
  assign o_s1_upd_prod_id_r = s1_id_q;
  assign o_s2_upd_vld_r     = s2_vld_q;
  assign o_s2_upd_prod_id_r = s2_id_q;
  assign o_s3_upd_vld_r     = s3_vld_q;
  assign o_s3_upd_prod_id_r = s3_id_q;
  assign o_s4_upd_vld_r     = s4_vld_q;
  assign o_s4_upd_prod_id_r = s4_id_q;
  assign o_upd_resp_vld_r   = s4_vld_q;
  assign o_upd_resp_error_r = resp_err_q;

endmodule

// File: tb/tb_v_pipe_update.sv
// Self-checking bench for v_pipe_update: vector table plus scoreboard on writes and responses.
module tb_v_pipe_update;
  import v_pkg::*;

  logic       clk = 1'b0;
  logic       arst;
  logic       i_upd_vld;
  id_t        i_upd_prod_id;
  level_t     i_upd_level;
  logic [1:0] i_upd_cmd;
  key_t       i_upd_key;
  volume_t    i_upd_size;
  logic       o_upd_rdy;
  logic       o_state_ren;
  addr_t      o_state_raddr;
  state_t     i_state_rdata;
  logic       o_state_wen;
  addr_t      o_state_waddr;
  state_t     o_state_wdata;
  logic       o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r;
  id_t        o_s1_upd_prod_id_r, o_s2_upd_prod_id_r, o_s3_upd_prod_id_r, o_s4_upd_prod_id_r;
  logic       o_upd_resp_vld_r;
  logic       o_upd_resp_error_r;
`ifdef V_PIPE_UPDATE_ERRCNT_EN
  logic [15:0] o_upd_err_cnt_r;
`endif

  v_pipe_update dut (
    .clk                (clk),
    .arst               (arst),
    .i_upd_vld          (i_upd_vld),
    .i_upd_prod_id      (i_upd_prod_id),
    .i_upd_level        (i_upd_level),
    .i_upd_cmd          (i_upd_cmd),
    .i_upd_key          (i_upd_key),
    .i_upd_size         (i_upd_size),
    .o_upd_rdy          (o_upd_rdy),
    .o_state_ren        (o_state_ren),
    .o_state_raddr      (o_state_raddr),
    .i_state_rdata      (i_state_rdata),
    .o_state_wen        (o_state_wen),
    .o_state_waddr      (o_state_waddr),
    .o_state_wdata      (o_state_wdata),
    .o_s1_upd_vld_r     (o_s1_upd_vld_r),
    .o_s1_upd_prod_id_r (o_s1_upd_prod_id_r),
    .o_s2_upd_vld_r     (o_s2_upd_vld_r),
    .o_s2_upd_prod_id_r (o_s2_upd_prod_id_r),
    .o_s3_upd_vld_r     (o_s3_upd_vld_r),
    .o_s3_upd_prod_id_r (o_s3_upd_prod_id_r),
    .o_s4_upd_vld_r     (o_s4_upd_vld_r),
    .o_s4_upd_prod_id_r (o_s4_upd_prod_id_r),
    .o_upd_resp_vld_r   (o_upd_resp_vld_r),
`ifdef V_PIPE_UPDATE_ERRCNT_EN
    .o_upd_err_cnt_r    (o_upd_err_cnt_r),
`endif
    .o_upd_resp_error_r (o_upd_resp_error_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cmd;
    id_t        id;
    level_t     lv;
    logic       err;
    listsize_t  ls;
    int         stall;
  } vec_t;

  typedef struct {
    int        acc;
    id_t       id;
    state_t    st;
    listsize_t ls;
  } wr_t;

  typedef struct {
    int   acc;
    id_t  id;
    logic err;
  } rsp_t;

  state_t mem     [16];
  state_t ref_mem [16];
  state_t snap    [16];
  wr_t    wr_q    [$];
  rsp_t   rsp_q   [$];
  wr_t    w_pop;
  rsp_t   r_pop;
  vec_t   tbl     [13];
  int     cyc = 0;
  int     n_chk = 0;
  int     n_pass = 0;
  int     st;

  // Synchronous-read state RAM; a write is seen by reads issued from the next cycle.
  always @(posedge clk) begin
    if (o_state_wen) mem[o_state_waddr] <= o_state_wdata;
    if (o_state_ren) i_state_rdata <= mem[o_state_raddr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (o_state_wen) begin
        if (wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_write: got write to %0h want none (cycle %0d)", o_state_waddr, cyc);
        end else begin
          w_pop = wr_q.pop_front();
          chk("wr_addr", 256'(o_state_waddr), 256'(w_pop.id));
          chk("wr_data", 256'(o_state_wdata), 256'(w_pop.st));
          chk("wr_listsize", 256'(o_state_wdata.listsize), 256'(w_pop.ls));
          chk("wr_latency", 256'(cyc - w_pop.acc), 256'(3));
        end
      end
      if (o_upd_resp_vld_r) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_resp: got response id %0h want none (cycle %0d)", o_s4_upd_prod_id_r, cyc);
        end else begin
          r_pop = rsp_q.pop_front();
          chk("resp_error", 256'(o_upd_resp_error_r), 256'(r_pop.err));
          chk("resp_id", 256'(o_s4_upd_prod_id_r), 256'(r_pop.id));
          chk("resp_latency", 256'(cyc - r_pop.acc), 256'(4));
        end
      end
    end
  end

  // Drive one command, wait (bounded) for acceptance, and post expectations.
  task automatic issue(input logic [1:0] cmd, input id_t id, input level_t lv, input key_t k,
                       input volume_t v, input logic e_err, input listsize_t e_ls, output int stall);
    state_t ns;
    wr_t    w;
    rsp_t   r;
    @(negedge clk);
    i_upd_vld     = 1'b1;
    i_upd_cmd     = cmd;
    i_upd_prod_id = id;
    i_upd_level   = lv;
    i_upd_key     = k;
    i_upd_size    = v;
    stall = 0;
    #1;
    while (!o_upd_rdy && stall < 20) begin
      stall++;
      @(negedge clk);
      #1;
    end
    if (!o_upd_rdy) begin
      n_chk++;
      $display("FAIL accept_timeout: got rdy 0 want 1 for id %0d", id);
      i_upd_vld = 1'b0;
      return;
    end
    ns = ref_mem[id];
    if (cmd == 2'd0) begin
      ns.vld[lv]    = 1'b1;
      ns.key[lv]    = k;
      ns.volume[lv] = v;
      ns.listsize   = listsize_t'(ns.listsize + 1);
    end else if (cmd == 2'd1) begin
      ns.vld[lv]  = 1'b0;
      ns.listsize = listsize_t'(ns.listsize - 1);
    end else if (cmd == 2'd2) begin
      ns.key[lv]    = k;
      ns.volume[lv] = v;
    end
    r.acc = cyc;
    r.id  = id;
    r.err = e_err;
    rsp_q.push_back(r);
    if (!e_err) begin
      ref_mem[id] = ns;
      w.acc = cyc;
      w.id  = id;
      w.st  = ns;
      w.ls  = e_ls;
      wr_q.push_back(w);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    i_upd_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    //        cmd    id     lv    err   ls    stall
    tbl[0]  = '{2'd0, 4'd3, 2'd0, 1'b0, 3'd1, 0};
    tbl[1]  = '{2'd0, 4'd3, 2'd0, 1'b1, 3'd1, 3};
    tbl[2]  = '{2'd0, 4'd5, 2'd0, 1'b0, 3'd1, 0};
    tbl[3]  = '{2'd0, 4'd5, 2'd1, 1'b0, 3'd2, 3};
    tbl[4]  = '{2'd0, 4'd1, 2'd0, 1'b0, 3'd1, 0};
    tbl[5]  = '{2'd0, 4'd2, 2'd0, 1'b0, 3'd1, 0};
    tbl[6]  = '{2'd0, 4'd1, 2'd1, 1'b0, 3'd2, 2};
    tbl[7]  = '{2'd0, 4'd2, 2'd1, 1'b0, 3'd2, 0};
    tbl[8]  = '{2'd1, 4'd7, 2'd2, 1'b1, 3'd0, 0};
    tbl[9]  = '{2'd2, 4'd5, 2'd1, 1'b0, 3'd2, 0};
    tbl[10] = '{2'd1, 4'd5, 2'd0, 1'b0, 3'd1, 3};
    tbl[11] = '{2'd3, 4'd9, 2'd0, 1'b1, 3'd0, 0};
    tbl[12] = '{2'd0, 4'd5, 2'd0, 1'b0, 3'd2, 2};

    for (int i = 0; i < 16; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    arst = 1'b1;
    i_upd_vld = 1'b0;
    i_upd_cmd = 2'd0;
    i_upd_prod_id = '0;
    i_upd_level = '0;
    i_upd_key = '0;
    i_upd_size = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s1_vld", 256'(o_s1_upd_vld_r), 256'(0));
    chk("rst_s4_vld", 256'(o_s4_upd_vld_r), 256'(0));
    chk("rst_wen", 256'(o_state_wen), 256'(0));
    chk("rst_resp_vld", 256'(o_upd_resp_vld_r), 256'(0));
    chk("rst_resp_err", 256'(o_upd_resp_error_r), 256'(0));
    chk("rst_rdy", 256'(o_upd_rdy), 256'(1));
    arst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].cmd, tbl[i].id, tbl[i].lv, key_t'(32'h1000 + i), volume_t'(32'h0100 + i),
            tbl[i].err, tbl[i].ls, st);
      chk($sformatf("stall_row%0d", i), 256'(st), 256'(tbl[i].stall));
    end
    idle(8);
    chk("wr_q_drained", 256'(wr_q.size()), 256'(0));
    chk("rsp_q_drained", 256'(rsp_q.size()), 256'(0));
`ifdef V_PIPE_UPDATE_ERRCNT_EN
    chk("err_cnt", 256'(o_upd_err_cnt_r), 256'(3));
`endif

    // Reset with three commands in flight: none of them may write or respond.
    snap = ref_mem;
    issue(2'd0, 4'd10, 2'd0, 16'hAAAA, 16'h000A, 1'b0, 3'd1, st);
    issue(2'd0, 4'd11, 2'd0, 16'hBBBB, 16'h000B, 1'b0, 3'd1, st);
    issue(2'd0, 4'd12, 2'd0, 16'hCCCC, 16'h000C, 1'b0, 3'd1, st);
    #1;
    chk("pre_rst_s1_id", 256'(o_s1_upd_prod_id_r), 256'(12));
    chk("pre_rst_s2_id", 256'(o_s2_upd_prod_id_r), 256'(11));
    chk("pre_rst_s3_id", 256'(o_s3_upd_prod_id_r), 256'(10));
    chk("pre_rst_wen", 256'(o_state_wen), 256'(1));
    arst = 1'b1;
    i_upd_vld = 1'b0;
    #1;
    chk("arst_vlds", 256'({o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r}), 256'(0));
    chk("arst_wen", 256'(o_state_wen), 256'(0));
    chk("arst_rdy", 256'(o_upd_rdy), 256'(1));
`ifdef V_PIPE_UPDATE_ERRCNT_EN
    chk("arst_err_cnt", 256'(o_upd_err_cnt_r), 256'(0));
`endif
    @(negedge clk);
    chk("arst_resp_vld", 256'(o_upd_resp_vld_r), 256'(0));
    arst = 1'b0;
    ref_mem = snap;
    wr_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 256'({o_upd_resp_vld_r, o_state_wen, o_s4_upd_vld_r}), 256'(0));
    end
    issue(2'd0, 4'd10, 2'd0, 16'hDDDD, 16'h000D, 1'b0, 3'd1, st);
    issue(2'd0, 4'd12, 2'd0, 16'hEEEE, 16'h000E, 1'b0, 3'd1, st);
    idle(8);
    chk("wr_q_drained2", 256'(wr_q.size()), 256'(0));
    chk("rsp_q_drained2", 256'(rsp_q.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_pipe_update.md
V_PIPE_UPDATE -- requirements
Module: v_pipe_update

Interface
REQ-001 SHALL have parameters: none. Widths come from v_pkg: id_t, level_t, key_t, volume_t, listsize_t, state_t, addr_t, ENTRIES_N.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock.
- arst, in, 1, reset; asynchronous, active-high.
- i_upd_vld, in, 1, command valid.
- i_upd_prod_id, in, id_t, product id.
- i_upd_level, in, level_t, entry index.
- i_upd_cmd, in, 2, 0=ADD, 1=DELETE, 2=REPLACE, 3=reserved.
- i_upd_key, in, key_t, key to write.
- i_upd_size, in, volume_t, volume to write.
- o_upd_rdy, out, 1, command accepted when i_upd_vld & o_upd_rdy.
- o_state_ren, out, 1, state RAM read enable.
- o_state_raddr, out, addr_t, state RAM read address.
- i_state_rdata, in, state_t, read data, one cycle after ren.
- o_state_wen, out, 1, state RAM write enable.
- o_state_waddr, out, addr_t, state RAM write address.
- o_state_wdata, out, state_t, state RAM write data.
- o_sN_upd_vld_r, out, 1, stage N valid, N=1..4 (query-pipe busy check).
- o_sN_upd_prod_id_r, out, id_t, stage N product id, N=1..4.
- o_upd_resp_vld_r, out, 1, completion strobe.
- o_upd_resp_error_r, out, 1, command rejected.

Function
REQ-003 SHALL accept a command in S0 when i_upd_vld & o_upd_rdy, driving o_state_ren=1 and o_state_raddr=i_upd_prod_id that cycle.
REQ-004 SHALL deassert o_upd_rdy, combinationally, while any valid S1..S3 holds the same prod_id as i_upd_prod_id. Other ids are never stalled; throughput is 1 command/cycle.
REQ-005 SHALL advance each accepted command S0->S1->S2->S3->S4, one stage per cycle, with no internal backpressure.
REQ-006 S1 SHALL decode the level one-hot (ENTRIES_N), sample i_state_rdata, and evaluate the error:
- ADD errors when the entry is already valid.
- DELETE or REPLACE errors when the entry is invalid.
- cmd=3 always errors.
REQ-007 S1 SHALL compute the new state, which S2 registers:
- ADD: set vld[level], key[level], volume[level]; listsize+1.
- DELETE: clear vld[level]; listsize-1; key/volume unchanged.
- REPLACE: overwrite key[level] and volume[level]; listsize unchanged.
REQ-008 An erroring command SHALL NOT write. Its S3 o_state_wen=0, but it still occupies every stage.
REQ-009 In S3, o_state_wen=1, o_state_waddr=prod_id and o_state_wdata=new state; the write is visible to reads issued the following cycle.
REQ-010 listsize arithmetic SHALL be modulo its width. Given REQ-006, listsize never leaves 0..ENTRIES_N.
REQ-011 In S4, o_upd_resp_vld_r=1 for one cycle with o_upd_resp_error_r. Latency from accept to response is 4 cycles.
REQ-012 A command to an id whose previous command sits in S4 SHALL be accepted and SHALL read the updated state.

Reset
REQ-013 arst SHALL asynchronously clear all stage valids, o_state_wen, o_upd_resp_vld_r, o_upd_resp_error_r and the error counter. o_upd_rdy is 1 after reset.
REQ-014 Datapath flops SHALL be non-reset and enabled only by their stage valid. A reset mid-operation drops in-flight commands and leaves the RAM with only the writes already issued.

Configuration
REQ-015 Macro V_PIPE_UPDATE_ERRCNT_EN, when defined, SHALL add output o_upd_err_cnt_r (16 bits), counting errored responses and saturating at 0xFFFF. When undefined, the port and counter are absent and there is no other behaviour change.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- ADD id=3, level=0 to an empty state -> write at S3 with vld=1, listsize=1; response error=0 at accept+4.
- ADD id=3, level=0 again -> no write; response error=1; with the macro defined, err_cnt=1.
- ADD id=5 on back-to-back cycles, levels 0 then 1 -> o_upd_rdy=0 for 3 cycles; second accepted at t+4; final listsize=2.
- Interleaved ids 1,2,1,2 -> 1,2 accepted back-to-back; 3rd stalls 2 cycles, 4th 0 further; all succeed.
- DELETE id=7, level=2 with entry invalid -> error=1, no write; REPLACE on a valid entry -> listsize unchanged.
- Assert arst with 3 commands in flight -> all valids 0 next edge; no responses; o_upd_rdy=1.
